// File: rtl/bloco_controle_pkg.sv
// +--------------------------------------------------------------------+
// | bloco_controle_pkg                                                 |
// | State encoding and per-state control words {lx,m0,m1,m2,h,ls,lh}. |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package bloco_controle_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_T1   = 3'd2,
    ST_T2   = 3'd3,
    ST_T3   = 3'd4,
    ST_T4   = 3'd5,
    ST_DONE = 3'd6
  } state_t;

  localparam int unsigned CW_W = 7;

  localparam logic [CW_W-1:0] c_cw_idle = 7'b0000000;
  localparam logic [CW_W-1:0] c_cw_load = 7'b1000000;
  localparam logic [CW_W-1:0] c_cw_t1   = 7'b0000001;  // H <= a*X
  localparam logic [CW_W-1:0] c_cw_t2   = 7'b0110101;  // H <= H+b
  localparam logic [CW_W-1:0] c_cw_t3   = 7'b0100001;  // H <= H*X
  localparam logic [CW_W-1:0] c_cw_t4   = 7'b0111110;  // S <= H+c
  localparam logic [CW_W-1:0] c_cw_done = 7'b0000000;

endpackage

`default_nettype wire

// File: rtl/bloco_controle.sv
// +--------------------------------------------------------------------+
// | bloco_controle                                                     |
// | Moore sequencer for y = a*x^2 + b*x + c on the shared-ALU datapath.|
// | Optional macro BLOCO_CONTROLE_SINGLE_STEP_EN adds a step input.    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module bloco_controle
  import bloco_controle_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic start,
`ifdef BLOCO_CONTROLE_SINGLE_STEP_EN
  input  logic step,
`endif
  output logic lx,
  output logic m0,
  output logic m1,
  output logic m2,
  output logic h,
  output logic ls,
  output logic lh,
  output logic busy,
  output logic done
);

  state_t          r_state;
  state_t          w_next;
  logic            w_adv;
  logic [CW_W-1:0] w_cw;

`ifdef BLOCO_CONTROLE_SINGLE_STEP_EN
  assign w_adv = step;
`else
  assign w_adv = 1'b1;
`endif

  always_ff @(posedge clock) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = ST_IDLE;
    case (r_state)
      ST_IDLE: w_next = start ? ST_LOAD : ST_IDLE;
      ST_LOAD: w_next = w_adv ? ST_T1   : ST_LOAD;
      ST_T1:   w_next = w_adv ? ST_T2   : ST_T1;
      ST_T2:   w_next = w_adv ? ST_T3   : ST_T2;
      ST_T3:   w_next = w_adv ? ST_T4   : ST_T3;
      ST_T4:   w_next = w_adv ? ST_DONE : ST_T4;
      ST_DONE: w_next = w_adv ? ST_IDLE : ST_DONE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Unused encodings decode to an all-zero word and fall back to IDLE.
  always_comb begin
    w_cw = c_cw_idle;
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      ST_LOAD: begin w_cw = c_cw_load; busy = 1'b1; end
      ST_T1:   begin w_cw = c_cw_t1;   busy = 1'b1; end
      ST_T2:   begin w_cw = c_cw_t2;   busy = 1'b1; end
      ST_T3:   begin w_cw = c_cw_t3;   busy = 1'b1; end
      ST_T4:   begin w_cw = c_cw_t4;   busy = 1'b1; end
      ST_DONE: begin w_cw = c_cw_done; busy = 1'b1; done = 1'b1; end
      default: begin w_cw = c_cw_idle; busy = 1'b0; done = 1'b0; end
    endcase
  end

  assign {lx, m0, m1, m2, h, ls, lh} = w_cw;

endmodule

`default_nettype wire

// File: tb/tb_bloco_controle.sv
// Testbench for bloco_controle: phase-counter reference model plus a
// behavioural quadratic datapath driven by the DUT control word.
`default_nettype none
`timescale 1ns/1ps

module tb_bloco_controle;

  logic clock = 1'b0;
  logic reset;
  logic start;
`ifdef BLOCO_CONTROLE_SINGLE_STEP_EN
  logic step;
`endif
  logic lx, m0, m1, m2, h, ls, lh, busy, done;

  bloco_controle dut (
    .clock (clock),
    .reset (reset),
    .start (start),
`ifdef BLOCO_CONTROLE_SINGLE_STEP_EN
    .step  (step),
`endif
    .lx    (lx),
    .m0    (m0),
    .m1    (m1),
    .m2    (m2),
    .h     (h),
    .ls    (ls),
    .lh    (lh),
    .busy  (busy),
    .done  (done)
  );

  always #5 clock = ~clock;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference: phase 0 = idle, 1 = load, 2..5 = T1..T4, 6 = done.
  int         ph = 0;
  logic [6:0] exp_tab [7];
  int         n_edge = 0;
  int         n_done = 0;
  int         n_ls   = 0;
  int         first_done = -1;
  int         last_done  = -1;
  int         start_edge = 0;

  // Behavioural datapath with a = b = c = x = 1.
  logic [7:0] dx, dh, ds;
  logic [6:0] pcw = 7'b0;
  localparam logic [7:0] VA = 8'd1, VB = 8'd1, VC = 8'd1, VX = 8'd1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic clr_counts();
    n_done = 0; n_ls = 0; first_done = -1; last_done = -1;
  endtask

  // One clock edge: advance the model, update the datapath, compare.
  task automatic tick(input string tag);
    bit         adv;
    logic [7:0] opa, opb, alu;
    @(posedge clock);
`ifdef BLOCO_CONTROLE_SINGLE_STEP_EN
    adv = step;
`else
    adv = 1'b1;
`endif
    if (!reset)       ph = 0;
    else if (ph == 0) ph = start ? 1 : 0;
    else if (adv)     ph = (ph + 1) % 7;
    n_edge++;
    #1;
    opa = pcw[5] ? dh : VA;
    opb = pcw[4] ? (pcw[3] ? VC : VB) : dx;
    alu = pcw[2] ? opa + opb : opa * opb;
    if (pcw[6]) dx = VX;
    if (pcw[0]) dh = alu;
    if (pcw[1]) ds = alu;
    pcw = {lx, m0, m1, m2, h, ls, lh};
    chk({tag, ":cw"},   {25'b0, pcw}, {25'b0, exp_tab[ph]});
    chk({tag, ":busy"}, {31'b0, busy}, {31'b0, (ph != 0)});
    chk({tag, ":done"}, {31'b0, done}, {31'b0, (ph == 6)});
    chk({tag, ":excl"}, {31'b0, ($countones({lx, lh, ls}) <= 1)}, 32'd1);
    if (ls) n_ls++;
    if (done) begin
      n_done++;
      if (first_done < 0) first_done = n_edge;
      last_done = n_edge;
    end
  endtask

  initial begin
    exp_tab = '{7'b0000000, 7'b1000000, 7'b0000001, 7'b0110101,
                7'b0100001, 7'b0111110, 7'b0000000};
    reset = 1'b0;
    start = 1'b0;
`ifdef BLOCO_CONTROLE_SINGLE_STEP_EN
    step  = 1'b1;
`endif

    // Reset then idle
    tick("rst");
    tick("rst");
    #2 reset = 1'b1;
    for (int i = 0; i < 10; i++) tick("idle");

    // Single run; done is seen 5 edges after the start edge (cycle N+6)
    clr_counts();
    start = 1'b1;
    tick("single");
    start_edge = n_edge;
    start = 1'b0;
    for (int i = 0; i < 8; i++) tick("single");
    chk("single:ndone", n_done, 1);
    chk("single:latency", first_done - start_edge, 5);
    chk("single:result", {24'b0, ds}, 32'd3);

    // Start pulses in T2 and T4 are ignored
    clr_counts();
    start = 1'b1; tick("busy");
    start = 1'b0; tick("busy"); tick("busy");
    start = 1'b1; tick("busy");
    start = 1'b0; tick("busy");
    start = 1'b1; tick("busy");
    start = 1'b0; tick("busy");
    chk("busy:idle_n7", {31'b0, busy}, 32'd0);
    for (int i = 0; i < 8; i++) tick("busy");
    chk("busy:ndone", n_done, 1);

    // Continuous start for 21 cycles
    clr_counts();
    start = 1'b1;
    for (int i = 0; i < 21; i++) tick("cont");
    start = 1'b0;
    for (int i = 0; i < 8; i++) tick("cont");
    chk("cont:ndone", n_done, 3);
    chk("cont:spacing", last_done - first_done, 14);

    // Reset during T3
    clr_counts();
    start = 1'b1; tick("abort");
    start = 1'b0; tick("abort"); tick("abort"); tick("abort");
    reset = 1'b0; tick("abort");
    chk("abort:idle", {31'b0, busy}, 32'd0);
    reset = 1'b1;
    for (int i = 0; i < 8; i++) tick("abort");
    chk("abort:ndone", n_done, 0);
    chk("abort:nls", n_ls, 0);

`ifdef BLOCO_CONTROLE_SINGLE_STEP_EN
    // Step every third cycle: each state held 3 cycles
    clr_counts();
    step  = 1'b0;
    start = 1'b1; tick("step");
    start = 1'b0;
    for (int i = 0; i < 24; i++) begin
      step = (i % 3 == 2);
      tick("step");
    end
    step = 1'b1;
    chk("step:done_cycles", n_done, 3);
    chk("step:done_span", last_done - first_done, 2);
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      start = ($urandom_range(0, 2) == 0);
      reset = ($urandom_range(0, 24) != 0);
`ifdef BLOCO_CONTROLE_SINGLE_STEP_EN
      step  = ($urandom_range(0, 1) == 1);
`endif
      tick("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/bloco_controle.md
BLOCO_CONTROLE -- requirements
Module: bloco_controle

Interface
REQ-001 No parameters; the block is fixed to the 7-signal control word of the quadratic-equation datapath.
REQ-002 clock  input  1  single system clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-low reset.
REQ-004 start  input  1  request one evaluation of y = a*x^2 + b*x + c; sampled only in IDLE.
REQ-005 lx  output  1  load X register from x.
REQ-006 m0  output  1  datapath operand-A select: 0 = a, 1 = H.
REQ-007 m1  output  1  operand-B select: 0 = X, 1 = coefficient chosen by m2.
REQ-008 m2  output  1  coefficient select: 0 = b, 1 = c.
REQ-009 h  output  1  ALU operation: 0 = multiply, 1 = add.
REQ-010 ls  output  1  load result register S from ALU output.
REQ-011 lh  output  1  load partial register H from ALU output.
REQ-012 busy  output  1  high from LOAD through DONE inclusive.
REQ-013 done  output  1  one-cycle pulse when S holds a valid result.

Function
REQ-014 Moore FSM; all outputs decode from the current state only; no output depends combinationally on start.
REQ-015 States and order: IDLE -> LOAD -> T1 -> T2 -> T3 -> T4 -> DONE -> IDLE.
REQ-016 IDLE: all outputs 0; start = 1 moves to LOAD; start = 0 stays in IDLE.
REQ-017 LOAD: lx = 1; all other control outputs 0.
REQ-018 T1 (H <= a*X): m0 = 0, m1 = 0, m2 = 0, h = 0, lh = 1, ls = 0.
REQ-019 T2 (H <= H+b): m0 = 1, m1 = 1, m2 = 0, h = 1, lh = 1, ls = 0.
REQ-020 T3 (H <= H*X): m0 = 1, m1 = 0, m2 = 0, h = 0, lh = 1, ls = 0.
REQ-021 T4 (S <= H+c): m0 = 1, m1 = 1, m2 = 1, h = 1, ls = 1, lh = 0.
REQ-022 DONE: done = 1; all other control outputs 0; unconditional return to IDLE.
REQ-023 LOAD through T4 advance every cycle regardless of start.
REQ-024 Latency: start sampled high at edge N puts LOAD in cycle N+1 and done in cycle N+6; busy is low again in cycle N+7.
REQ-025 start asserted while busy is ignored; it is neither queued nor counted.
REQ-026 start held high continuously re-triggers from IDLE: one evaluation every 7 cycles.
REQ-027 lx, lh and ls are never high in the same cycle.
REQ-028 Unused state encodings go to IDLE on the next edge, with all outputs 0.

Reset
REQ-029 reset = 0 at a rising edge forces IDLE with all outputs 0, overriding start and the step input of REQ-031.
REQ-030 reset asserted mid-sequence (any of LOAD..DONE) aborts without a done pulse; after release, a new start is required.

Configuration
REQ-031 With macro BLOCO_CONTROLE_SINGLE_STEP_EN defined: extra input step (1 bit); LOAD..DONE advance only on edges where step = 1, holding outputs otherwise; IDLE behaviour is unchanged (start only).
REQ-032 Without BLOCO_CONTROLE_SINGLE_STEP_EN: no step port; the timing of REQ-023 and REQ-024 applies.

Structure
REQ-033 Shared package bloco_controle_pkg holds the state enumeration (3-bit encoding, IDLE = 0) and named constants for the 7-bit control word {lx,m0,m1,m2,h,ls,lh} per state.
REQ-034 No sub-module: one state register plus one combinational decoder in a single module; integration connects its outputs to BlocoOpeartivo in place of the switch inputs.

Verification
REQ-035 Reset then idle: reset = 0 for 2 cycles, start = 0 -> all outputs 0, busy = 0 for 10 cycles.
REQ-036 Single run: 1-cycle start pulse -> control words LOAD 1000000, T1 0000001, T2 0110101, T3 0100001, T4 0111110 on consecutive cycles; done in cycle N+6; with a = b = c = x = 1 the datapath result is 3.
REQ-037 Start while busy: start pulses in T2 and T4 -> exactly one done pulse; IDLE is reached at N+7.
REQ-038 Continuous start: held high for 21 cycles -> exactly 3 done pulses, 7 cycles apart.
REQ-039 Reset mid-run: reset = 0 during T3 -> IDLE next cycle, no done pulse, no ls pulse.
REQ-040 With BLOCO_CONTROLE_SINGLE_STEP_EN: step pulsed every 3rd cycle -> each state is held 3 cycles and done is asserted for exactly 3 cycles.
